// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, MEM-stage and memory-side signals around the shared
// instruction/data memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              flush_if;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_fetch;
  logic              stall_mem;
  logic              bus_err;

  // Arbiter side.
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           flush_if, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we,
           mem_be, mem_addr, mem_wdata, stall_fetch, stall_mem, bus_err
  );

  // Pipeline and memory side.
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           flush_if, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we,
           mem_be, mem_addr, mem_wdata, stall_fetch, stall_mem, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes IF fetches and MEM data accesses onto one memory port, data first,
// with fetch discard on branch flush and an access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DROP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [3:0]        mem_be_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;
  logic              if_ready_reg, dm_ready_reg, bus_err_reg;

  logic grant_d, grant_i, done_d, done_i, timeout, clr_cnt, timed_out;
  logic [DATA_W-1:0] resp_data;

  assign timed_out = (cnt_reg == TO_LAST) && !bus.mem_ack;
  assign resp_data = timeout ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done_d     = 1'b0;
    done_i     = 1'b0;
    timeout    = 1'b0;
    clr_cnt    = 1'b0;
    case (state_reg)
      IDLE: begin
        // A requester whose ready is pulsing right now has not yet seen it,
        // so its still-asserted req refers to the access just completed.
        if (bus.dm_req && !dm_ready_reg) begin
          grant_d    = 1'b1;
          clr_cnt    = 1'b1;
          state_next = BUSY_D;
        end else if (bus.if_req && !bus.flush_if && !if_ready_reg) begin
          grant_i    = 1'b1;
          clr_cnt    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          done_d     = 1'b1;
          state_next = IDLE;
        end else if (timed_out) begin
          done_d     = 1'b1;
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          done_i     = !bus.flush_if;
          state_next = IDLE;
        end else if (timed_out) begin
          done_i     = !bus.flush_if;
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (bus.flush_if) begin
          clr_cnt    = 1'b1;
          state_next = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_next = IDLE;
        end else if (timed_out) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_ready_reg  <= 1'b0;
      dm_ready_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      if_ready_reg <= done_i;
      dm_ready_reg <= done_d;
      bus_err_reg  <= timeout;
      if (done_i) if_rdata_reg <= resp_data;
      if (done_d) dm_rdata_reg <= resp_data;

      if (grant_d) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= bus.dm_we;
        mem_be_reg    <= bus.dm_be;
        mem_addr_reg  <= bus.dm_addr;
        mem_wdata_reg <= bus.dm_wdata;
      end else if (grant_i) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= 1'b0;
        mem_be_reg    <= 4'hF;
        mem_addr_reg  <= bus.if_addr;
        mem_wdata_reg <= '0;
      end else if (state_next == IDLE) begin
        mem_req_reg   <= 1'b0;
      end

      if (clr_cnt)
        cnt_reg <= '0;
      else if (state_reg != IDLE && !bus.mem_ack)
        cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_be      = mem_be_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.if_rdata    = if_rdata_reg;
  assign bus.if_ready    = if_ready_reg;
  assign bus.dm_rdata    = dm_rdata_reg;
  assign bus.dm_ready    = dm_ready_reg;
  assign bus.bus_err     = bus_err_reg;
  assign bus.stall_fetch = bus.if_req && !if_ready_reg;
  assign bus.stall_mem   = bus.dm_req && !dm_ready_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a latency-programmable memory model
// answers mem_req, and monitors compare every grant and every ready pulse.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed { logic is_d; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } acc_t;

  resp_t       resp_q[$];
  acc_t        acc_q[$];
  logic [31:0] mem_img [logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int ack_delay = 1;
  bit ack_en    = 1'b1;
  int wait_cnt  = 0;
  logic prev_req = 1'b0;

  function automatic logic [31:0] img(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks in the ack_delay-th cycle of an outstanding request.
  always @(negedge clk) begin
    if (!rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      wait_cnt      = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (bus.mem_req) begin
      wait_cnt++;
      if (ack_en && wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = img(bus.mem_addr);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Grant and completion monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_req && !prev_req) begin
        n_checks++;
        if (acc_q.size() == 0) begin
          $display("FAIL grant_unexpected: got addr=%h, required no access", bus.mem_addr);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          if (bus.mem_addr !== a.addr || bus.mem_we !== a.we || bus.mem_be !== a.be ||
              (a.we && bus.mem_wdata !== a.wdata))
            $display("FAIL grant: got addr=%h we=%b be=%h wdata=%h, required addr=%h we=%b be=%h wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata, a.addr, a.we, a.be, a.wdata);
          else
            n_pass++;
        end
      end
      if (bus.if_ready || bus.dm_ready) begin
        logic [31:0] got;
        got = bus.dm_ready ? bus.dm_rdata : bus.if_rdata;
        n_checks++;
        if (resp_q.size() == 0) begin
          $display("FAIL ready_unexpected: got if_ready=%b dm_ready=%b data=%h, required no ready",
                   bus.if_ready, bus.dm_ready, got);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          if (bus.dm_ready !== r.is_d || bus.if_ready === bus.dm_ready || got !== r.data)
            $display("FAIL response: got dm=%b if=%b data=%h, required dm=%b data=%h",
                     bus.dm_ready, bus.if_ready, got, r.is_d, r.data);
          else
            n_pass++;
          $display("txn %s data=%h", bus.dm_ready ? "data " : "fetch", got);
        end
      end
    end
    prev_req = bus.mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_d, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(is_d ? bus.dm_ready : bus.if_ready) && cycles < 100);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.dm_ready, bus.bus_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, required 00000",
               {bus.mem_req, bus.mem_we, bus.if_ready, bus.dm_ready, bus.bus_err});
    else n_pass++;
    n_checks++;
    if (bus.mem_be !== 4'h0) $display("FAIL reset_be: got %h, required 0", bus.mem_be);
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h, required 0", bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (bus.mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h, required 0", bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if ({bus.if_rdata, bus.dm_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h/%h, required 0/0", bus.if_rdata, bus.dm_rdata);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    int lat;
    bit stall_ok;
    mem_img[32'h100] = 32'h0050_0093;
    ack_delay = 3;
    resp_q.push_back('{1'b0, 32'h0050_0093});
    acc_q.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    lat = 0;
    stall_ok = 1'b1;
    while (lat < 50) begin
      tick();
      lat++;
      if (bus.if_ready) break;
      if (bus.stall_fetch !== 1'b1) stall_ok = 1'b0;
    end
    n_checks++;
    if (bus.if_ready !== 1'b1 || lat !== 4)
      $display("FAIL fetch_latency: got if_ready=%b after %0d cycles, required 1 after 4", bus.if_ready, lat);
    else n_pass++;
    n_checks++;
    if (!stall_ok) $display("FAIL fetch_stall: got stall_fetch dropping during wait, required 1");
    else n_pass++;
    n_checks++;
    if (bus.stall_fetch !== 1'b0) $display("FAIL fetch_stall_release: got %b, required 0", bus.stall_fetch);
    else n_pass++;
    tick();
    bus.if_req = 1'b0;
    n_checks++;
    if (bus.if_ready !== 1'b0 || bus.mem_req !== 1'b0)
      $display("FAIL fetch_served_mask: got if_ready=%b mem_req=%b, required 0/0", bus.if_ready, bus.mem_req);
    else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    int lat;
    mem_img[32'h2000] = 32'h1111_2222;
    mem_img[32'h104]  = 32'h3333_4444;
    ack_delay = 2;
    resp_q.push_back('{1'b1, 32'h1111_2222});
    resp_q.push_back('{1'b0, 32'h3333_4444});
    acc_q.push_back('{32'h2000, 1'b0, 4'hF, 32'h0});
    acc_q.push_back('{32'h104, 1'b0, 4'hF, 32'h0});
    bus.dm_addr = 32'h2000; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_req = 1'b1;
    bus.if_addr = 32'h104;  bus.if_req = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_we !== 1'b0)
      $display("FAIL priority_grant: got req=%b addr=%h we=%b, required 1/00002000/0",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    else n_pass++;
    wait_ready(1'b1, lat);
    n_checks++;
    if (bus.dm_ready !== 1'b1 || bus.dm_rdata !== 32'h1111_2222)
      $display("FAIL priority_load: got ready=%b data=%h, required 1/11112222", bus.dm_ready, bus.dm_rdata);
    else n_pass++;
    tick();
    bus.dm_req = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_be !== 4'hF)
      $display("FAIL back_to_back: got req=%b addr=%h be=%h, required 1/00000104/f",
               bus.mem_req, bus.mem_addr, bus.mem_be);
    else n_pass++;
    wait_ready(1'b0, lat);
    tick();
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int lat;
    int pulses;
    bit stable;
    ack_delay = 4;
    acc_q.push_back('{32'h2004, 1'b1, 4'b0011, 32'hABCD});
    resp_q.push_back('{1'b1, img(32'h2004)});
    bus.dm_we = 1'b1; bus.dm_be = 4'b0011; bus.dm_addr = 32'h2004;
    bus.dm_wdata = 32'hABCD; bus.dm_req = 1'b1;
    lat = 0;
    stable = 1'b1;
    while (lat < 50) begin
      tick();
      lat++;
      if (bus.dm_ready) break;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2004 || bus.mem_we !== 1'b1 ||
          bus.mem_be !== 4'b0011 || bus.mem_wdata !== 32'hABCD) stable = 1'b0;
    end
    n_checks++;
    if (!stable || lat !== 5)
      $display("FAIL store_stable: got stable=%b ready after %0d cycles, required 1 after 5", stable, lat);
    else n_pass++;
    pulses = bus.dm_ready ? 1 : 0;
    tick();
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dm_ready) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL store_ready_once: got %0d pulses, required 1", pulses);
    else n_pass++;
  endtask

  task automatic test_flush();
    int lat;
    mem_img[32'h108] = 32'hDEAD_BEEF;
    mem_img[32'h200] = 32'h0000_0013;
    ack_delay = 3;
    acc_q.push_back('{32'h108, 1'b0, 4'hF, 32'h0});
    acc_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0});
    resp_q.push_back('{1'b0, 32'h0000_0013});
    bus.if_addr = 32'h108; bus.if_req = 1'b1;
    tick();
    bus.flush_if = 1'b1;
    bus.if_addr  = 32'h200;
    tick();
    bus.flush_if = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h108)
      $display("FAIL drop_hold: got req=%b addr=%h, required 1/00000108", bus.mem_req, bus.mem_addr);
    else n_pass++;
    wait_ready(1'b0, lat);
    n_checks++;
    if (bus.if_ready !== 1'b1 || lat !== 6 || bus.if_rdata !== 32'h0000_0013)
      $display("FAIL flush_refetch: got ready=%b after %0d data=%h, required 1 after 6 data=00000013",
               bus.if_ready, lat, bus.if_rdata);
    else n_pass++;
    tick();
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_flush_at_ack();
    int pulses;
    ack_delay = 2;
    acc_q.push_back('{32'h10C, 1'b0, 4'hF, 32'h0});
    bus.if_addr = 32'h10C; bus.if_req = 1'b1;
    tick();
    tick();
    bus.flush_if = 1'b1;
    bus.if_req   = 1'b0;
    tick();
    bus.flush_if = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.if_ready) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0 || bus.mem_req !== 1'b0 || bus.if_rdata !== 32'h0000_0013)
      $display("FAIL flush_at_ack: got %0d if_ready, req=%b, if_rdata=%h, required 0/0/00000013",
               pulses, bus.mem_req, bus.if_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    int busy;
    bit stall_ok;
    ack_en = 1'b0;
    acc_q.push_back('{32'h3000, 1'b0, 4'hF, 32'h0});
    resp_q.push_back('{1'b1, 32'h0});
    bus.dm_addr = 32'h3000; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_req = 1'b1;
    k = 0; busy = 0; stall_ok = 1'b1;
    while (k < 40) begin
      tick();
      k++;
      if (bus.bus_err) break;
      if (bus.mem_req) busy++;
      if (bus.stall_mem !== 1'b1) stall_ok = 1'b0;
    end
    n_checks++;
    if (bus.bus_err !== 1'b1 || busy !== 8)
      $display("FAIL timeout_err: got bus_err=%b after %0d busy cycles, required 1 after 8", bus.bus_err, busy);
    else n_pass++;
    n_checks++;
    if (bus.dm_ready !== 1'b1 || bus.dm_rdata !== 32'h0 || bus.mem_req !== 1'b0)
      $display("FAIL timeout_resp: got ready=%b data=%h req=%b, required 1/0/0",
               bus.dm_ready, bus.dm_rdata, bus.mem_req);
    else n_pass++;
    n_checks++;
    if (!stall_ok) $display("FAIL timeout_stall: got stall_mem dropping during wait, required 1");
    else n_pass++;
    tick();
    bus.dm_req = 1'b0;
    n_checks++;
    if (bus.bus_err !== 1'b0) $display("FAIL timeout_pulse: got bus_err=%b, required 0", bus.bus_err);
    else n_pass++;
    ack_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    ack_en = 1'b0;
    acc_q.push_back('{32'h4000, 1'b0, 4'hF, 32'h0});
    bus.dm_addr = 32'h4000; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_req = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 ||
        bus.dm_ready !== 1'b0 || bus.bus_err !== 1'b0)
      $display("FAIL async_reset: got req=%b addr=%h be=%h, required 0/0/0",
               bus.mem_req, bus.mem_addr, bus.mem_be);
    else n_pass++;
    bus.dm_req = 1'b0;
    tick();
    rst = 1'b1;
    ack_en = 1'b1;
    tick();
    mem_img[32'h5000] = 32'hCAFE_F00D;
    ack_delay = 1;
    acc_q.push_back('{32'h5000, 1'b0, 4'hF, 32'h0});
    resp_q.push_back('{1'b1, 32'hCAFE_F00D});
    bus.dm_addr = 32'h5000; bus.dm_req = 1'b1;
    wait_ready(1'b1, lat);
    n_checks++;
    if (bus.dm_ready !== 1'b1 || lat !== 2 || bus.dm_rdata !== 32'hCAFE_F00D)
      $display("FAIL post_reset_load: got ready=%b after %0d data=%h, required 1 after 2 data=cafef00d",
               bus.dm_ready, lat, bus.dm_rdata);
    else n_pass++;
    tick();
    bus.dm_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.flush_if = 1'b0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_flush();
    test_flush_at_ack();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (resp_q.size() != 0 || acc_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d responses and %0d grants outstanding, required 0/0",
               resp_q.size(), acc_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end
endmodule
